crc_check: RTL and testbench

CRC_CHECK -- requirements
Module: crc_check

---
 rtl/crc_check.sv | 79 +++++++
 tb/tb_crc_check.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/crc_check.sv
// crc_check: serial 3-bit CRC checker; shifts the 17-bit codeword {Data, CRC}
// MSB first through a remainder register and reports the syndrome.
module crc_check (
    input  logic        clk,
    input  logic        Reset,
    input  logic        E,
    input  logic [13:0] Data,
    input  logic [2:0]  CRC,
    input  logic [3:0]  Divisor,
    output logic        Busy,
    output logic        Done,
    output logic [2:0]  Syndrome,
    output logic        Error,
    output logic [13:0] DataOut
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic        e_q;
    logic [16:0] cw_q;
    logic [2:0]  div_q, r_q, r_d, syn_q;
    logic [4:0]  cnt_q;
    logic        err_q;
    logic [13:0] dout_q;
    logic        start, last;
    logic        unused;

    // x^3 is implied by the feedback tap, so Divisor[3] carries no information
    assign unused = Divisor[3];
    assign start  = E & ~e_q;
    assign last   = cnt_q == 5'd16;
    assign r_d    = {r_q[1:0], cw_q[16]} ^ (r_q[2] ? div_q : 3'b000);

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            e_q     <= 1'b1;
            cw_q    <= '0;
            div_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            syn_q   <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            e_q     <= E;
            if (state_q == IDLE && start) begin
                cw_q   <= {Data, CRC};
                div_q  <= Divisor[2:0];
                dout_q <= Data;
                r_q    <= '0;
                cnt_q  <= '0;
            end else if (state_q == SHIFT) begin
                r_q   <= r_d;
                cw_q  <= {cw_q[15:0], 1'b0};
                cnt_q <= cnt_q + 5'd1;
                if (last) begin
                    syn_q <= r_d;
                    err_q <= |r_d;
                end
            end
        end
    end

    always_comb begin
        state_d = (state_q == IDLE && start) ? SHIFT :
                  (state_q == SHIFT && last) ? DONE  :
                  (state_q == DONE)          ? IDLE  : state_q;
    end

    always_comb begin
        Busy     = state_q == SHIFT;
        Done     = state_q == DONE;
        Syndrome = syn_q;
        Error    = err_q;
        DataOut  = dout_q;
    end
endmodule

// File: tb/tb_crc_check.sv
// tb_crc_check: directed and random checks of crc_check against a
// polynomial long-division reference model.
module tb_crc_check;
    logic        clk = 1'b0;
    logic        Reset, E;
    logic [13:0] Data;
    logic [2:0]  CRC;
    logic [3:0]  Divisor;
    logic        Busy, Done, Error;
    logic [2:0]  Syndrome;
    logic [13:0] DataOut;

    int n_checks = 0;
    int n_fail   = 0;

    crc_check dut (
        .clk(clk), .Reset(Reset), .E(E), .Data(Data), .CRC(CRC), .Divisor(Divisor),
        .Busy(Busy), .Done(Done), .Syndrome(Syndrome), .Error(Error), .DataOut(DataOut)
    );

    always #5 clk = ~clk;

    // remainder of the codeword polynomial modulo x^3 + Divisor[2:0]
    function automatic logic [2:0] ref_syn(input logic [13:0] d, input logic [2:0] c,
                                           input logic [3:0] v);
        logic [16:0] w;
        logic [16:0] g;
        w = {d, c};
        g = {13'd0, 1'b1, v[2:0]};
        for (int i = 16; i >= 3; i--)
            if (w[i]) w = w ^ (g << (i - 3));
        return w[2:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_check(input logic [13:0] d, input logic [2:0] c, input logic [3:0] v);
        int cyc;
        int busy_n;
        logic [2:0] es;
        es = ref_syn(d, c, v);
        @(negedge clk); E = 1'b0;
        @(negedge clk); Data = d; CRC = c; Divisor = v; E = 1'b1;
        @(posedge clk); #1;
        busy_n = int'(Busy);
        chk("start_busy", 32'(Busy), 32'd1);
        @(negedge clk);
        E = 1'b0; Data = 14'($urandom); CRC = 3'($urandom); Divisor = 4'($urandom);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (Done) break;
            busy_n += int'(Busy);
        end
        chk("latency", 32'(cyc), 32'd17);
        chk("busy_span", 32'(busy_n), 32'd17);
        chk("syndrome", 32'(Syndrome), 32'(es));
        chk("error", 32'(Error), 32'(|es));
        chk("dataout", 32'(DataOut), 32'(d));
        chk("busy_at_done", 32'(Busy), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(Done), 32'd0);
        chk("syndrome_hold", 32'(Syndrome), 32'(es));
    endtask

    initial begin
        int done_n;
        int busy_n;
        logic [13:0] d;
        logic [3:0]  v;
        Reset = 1'b0; E = 1'b1; Data = '0; CRC = '0; Divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_syn", 32'(Syndrome), 32'd0);
        chk("rst_err", 32'(Error), 32'd0);
        chk("rst_dout", 32'(DataOut), 32'd0);
        @(negedge clk); Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("e_high_through_reset", 32'(Busy), 32'd0);

        run_check(14'b11010011101100, 3'b100, 4'b1011);
        run_check(14'b11000110000110, 3'b010, 4'b1011);
        run_check(14'b11010011101100, 3'b101, 4'b1011);
        chk("flip_crc_syn", 32'(Syndrome), 32'b001);
        run_check(14'b11010011101101, 3'b100, 4'b1011);
        chk("flip_data_syn", 32'(Syndrome), 32'b011);
        run_check(14'h2a5c, 3'b110, 4'b0000);
        chk("div0_syn", 32'(Syndrome), 32'b110);

        // E held for 4 cycles with a re-pulse mid-shift: one check only
        @(negedge clk); E = 1'b0;
        @(negedge clk); Data = 14'b11010011101100; CRC = 3'b101; Divisor = 4'b1011;
        done_n = 0; busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); E = (i < 4) || (i == 8);
            @(posedge clk); #1;
            done_n += int'(Done);
            busy_n += int'(Busy);
        end
        chk("repulse_done_count", 32'(done_n), 32'd1);
        chk("repulse_busy_span", 32'(busy_n), 32'd17);
        chk("repulse_syn", 32'(Syndrome), 32'b001);

        // reset during the ninth shift cycle aborts the check
        @(negedge clk); E = 1'b0;
        @(negedge clk); Data = 14'h1357; CRC = 3'b011; Divisor = 4'b1101; E = 1'b1;
        @(posedge clk);
        @(negedge clk); E = 1'b0;
        repeat (8) @(negedge clk);
        Reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_syn", 32'(Syndrome), 32'd0);
        chk("abort_err", 32'(Error), 32'd0);
        chk("abort_dout", 32'(DataOut), 32'd0);
        @(negedge clk); Reset = 1'b1;
        done_n = 0;
        repeat (25) begin
            @(posedge clk); #1;
            done_n += int'(Done);
        end
        chk("abort_no_done", 32'(done_n), 32'd0);
        run_check(14'h1357, 3'b011, 4'b1101);

        for (int i = 0; i < 20; i++) begin
            d = 14'($urandom);
            v = 4'($urandom);
            if (i % 2 == 0) begin
                run_check(d, ref_syn(d, 3'b000, v), v);
                chk("gen_crc_zero", 32'(Syndrome), 32'd0);
            end else begin
                run_check(d, 3'($urandom), v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
